// File: rtl/crc_mem_pkg.sv
// Shared types and helpers for the CRC-protected memory bank.
package crc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SCAN = 2'd2
  } scrub_state_t;

  // Serial LFSR CRC, MSB first, no reflection, no final XOR.
  // Data up to 64 bits and CRC up to 32 bits; the live widths come in as arguments.
  function automatic logic [31:0] crc_compute(
    input logic [63:0] data,
    input int          data_w,
    input logic [31:0] poly,
    input int          poly_w,
    input logic [31:0] init
  );
    logic [31:0] crc;
    logic [31:0] mask;
    logic [4:0]  top;
    logic        fb;
    mask = (32'h1 << poly_w) - 32'h1;
    top  = 5'(poly_w - 1);
    crc  = init & mask;
    for (int i = 63; i >= 0; i--) begin
      if (i < data_w) begin
        fb  = crc[top] ^ data[6'(i)];
        crc = (crc << 1) & mask;
        if (fb) crc = crc ^ (poly & mask);
      end
    end
    return crc;
  endfunction

  // Increment that sticks at all-ones for a counter of width w (w <= 32).
  function automatic logic [31:0] sat_inc(
    input logic [31:0] val,
    input int          w
  );
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    if ((val & mask) == mask) return mask;
    return (val + 32'h1) & mask;
  endfunction

endpackage

// File: rtl/crc_mem_scrub_fsm.sv
// Background scrubber: waits an interval, then walks every word through the
// shared checker using only cycles the user port leaves free.
module crc_mem_scrub_fsm
  import crc_mem_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int SCRUB_INTERVAL = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_scrub_en,
  input  logic                  i_port_free,
  output logic                  o_scrub_busy,
  output logic                  o_scrub_done,
  output logic                  o_scrub_check,
  output logic [ADDR_WIDTH-1:0] o_scrub_addr
);

  localparam int                  CNT_W    = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  scrub_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic                  r_done, w_done_nxt;

  // State, interval counter, scan pointer and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; dropping scrub_en abandons the pass from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    if (!i_scrub_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
        S_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_SCAN;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_SCAN: begin
          // A stalled cycle (user traffic) holds the pointer.
          if (i_port_free) begin
            if (r_ptr == PTR_LAST) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = '0;
              w_ptr_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    o_scrub_busy  = (r_state == S_SCAN);
    o_scrub_check = (r_state == S_SCAN) && i_port_free && i_scrub_en;
    o_scrub_addr  = r_ptr;
    o_scrub_done  = r_done;
  end

endmodule

// File: rtl/crc_mem_bank.sv
// DEPTH-word memory with per-word CRC check bits, write-side error injection,
// a background scrubber and error bookkeeping shared by reads and scrubs.
module crc_mem_bank
  import crc_mem_pkg::*;
#(
  parameter int                         DATA_WIDTH      = 32,
  parameter int                         DEPTH           = 16,
  parameter int                         POLYNOMIAL_BITS = 8,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = 8'h07,
  parameter logic [POLYNOMIAL_BITS-1:0] CRC_INIT        = '0,
  parameter int                         OUTPUT_FF       = 1,
  parameter int                         SCRUB_INTERVAL  = 256,
  parameter int                         ERR_CNT_WIDTH   = 8,
  localparam int                        ADDR_WIDTH      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH-1:0]    inj_mask,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_err,
  input  logic                     scrub_en,
  output logic                     scrub_busy,
  output logic                     scrub_done,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     err_count_clr,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic                     err_sticky
);

  localparam logic [POLYNOMIAL_BITS-1:0] CRC_ZERO = POLYNOMIAL_BITS'(
    crc_compute(64'h0, DATA_WIDTH, 32'(POLYNOMIAL), POLYNOMIAL_BITS, 32'(CRC_INIT)));

  logic [DATA_WIDTH-1:0]      r_mem_data [DEPTH];
  logic [POLYNOMIAL_BITS-1:0] r_mem_crc  [DEPTH];

  logic                       w_port_free, w_user_rd;
  logic                       w_scrub_check;
  logic [ADDR_WIDTH-1:0]      w_scrub_addr;
  logic [POLYNOMIAL_BITS-1:0] w_wr_crc;
  logic [ADDR_WIDTH-1:0]      w_chk_addr;
  logic [DATA_WIDTH-1:0]      w_chk_data;
  logic [POLYNOMIAL_BITS-1:0] w_chk_crc;
  logic                       w_chk_mismatch, w_err_evt;

  logic                       r_vld_p1, r_rd_err_p1;
  logic [DATA_WIDTH-1:0]      r_rd_data_p1;
  logic [ERR_CNT_WIDTH-1:0]   r_err_count;
  logic [ADDR_WIDTH-1:0]      r_err_addr;
  logic                       r_err_sticky;

  // A write wins over a simultaneous read; the scrubber only gets idle cycles.
  assign w_port_free = ~wr_en & ~rd_en;
  assign w_user_rd   = rd_en & ~wr_en;

  // Check bits cover the intended data, so an injection mask shows up as a mismatch.
  assign w_wr_crc = POLYNOMIAL_BITS'(
    crc_compute(64'(wr_data), DATA_WIDTH, 32'(POLYNOMIAL), POLYNOMIAL_BITS, 32'(CRC_INIT)));

  crc_mem_scrub_fsm #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_scrub (
    .clk           (clk),
    .rst           (rst),
    .i_scrub_en    (scrub_en),
    .i_port_free   (w_port_free),
    .o_scrub_busy  (scrub_busy),
    .o_scrub_done  (scrub_done),
    .o_scrub_check (w_scrub_check),
    .o_scrub_addr  (w_scrub_addr)
  );

  // Storage: reset restores every word to a clean zero with matching check bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_crc[i]  <= CRC_ZERO;
      end
    end else if (wr_en) begin
      r_mem_data[addr] <= wr_data ^ inj_mask;
      r_mem_crc[addr]  <= w_wr_crc;
    end
  end

  // Single shared checker, steered to the user read address or the scrub pointer.
  assign w_chk_addr     = w_user_rd ? addr : w_scrub_addr;
  assign w_chk_data     = r_mem_data[w_chk_addr];
  assign w_chk_crc      = POLYNOMIAL_BITS'(
    crc_compute(64'(w_chk_data), DATA_WIDTH, 32'(POLYNOMIAL), POLYNOMIAL_BITS, 32'(CRC_INIT)));
  assign w_chk_mismatch = (w_chk_crc != r_mem_crc[w_chk_addr]);
  assign w_err_evt      = (w_user_rd | w_scrub_check) & w_chk_mismatch;

  // ---- stage p1: read word and check result captured ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_rd_data_p1 <= '0;
      r_rd_err_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= w_user_rd;
      if (w_user_rd) begin
        r_rd_data_p1 <= w_chk_data;
        r_rd_err_p1  <= w_chk_mismatch;
      end
    end
  end

  // ---- stage p2: optional output register ----
  generate
    if (OUTPUT_FF != 0) begin : g_out_ff
      logic                  r_vld_p2, r_rd_err_p2;
      logic [DATA_WIDTH-1:0] r_rd_data_p2;

      // Output register stage on the read path.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_p2     <= 1'b0;
          r_rd_data_p2 <= '0;
          r_rd_err_p2  <= 1'b0;
        end else begin
          r_vld_p2 <= r_vld_p1;
          if (r_vld_p1) begin
            r_rd_data_p2 <= r_rd_data_p1;
            r_rd_err_p2  <= r_rd_err_p1;
          end
        end
      end

      assign rd_valid = r_vld_p2;
      assign rd_data  = r_rd_data_p2;
      assign rd_err   = r_rd_err_p2;
    end else begin : g_out_direct
      assign rd_valid = r_vld_p1;
      assign rd_data  = r_rd_data_p1;
      assign rd_err   = r_rd_err_p1;
    end
  endgenerate

  // Error bookkeeping; a coincident clear and error leave exactly one error recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count  <= '0;
      r_err_addr   <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (err_count_clr) begin
        r_err_count  <= w_err_evt ? ERR_CNT_WIDTH'(1) : '0;
        r_err_sticky <= w_err_evt;
      end else if (w_err_evt) begin
        r_err_count  <= ERR_CNT_WIDTH'(sat_inc(32'(r_err_count), ERR_CNT_WIDTH));
        r_err_sticky <= 1'b1;
      end
      if (w_err_evt) r_err_addr <= w_chk_addr;
    end
  end

  assign err_count  = r_err_count;
  assign err_addr   = r_err_addr;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_crc_mem_bank.sv
// Directed bench for crc_mem_bank: 8-bit words, 16 deep, CRC-8 0x07,
// output register on, scrub interval 4, 2-bit error counter.
module tb_crc_mem_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [3:0] addr;
  logic [7:0] wr_data, inj_mask;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       scrub_en, scrub_busy, scrub_done;
  logic [1:0] err_count;
  logic       err_count_clr;
  logic [3:0] err_addr;
  logic       err_sticky;

  int n_total = 0;
  int n_pass  = 0;

  crc_mem_bank #(
    .DATA_WIDTH      (8),
    .DEPTH           (16),
    .POLYNOMIAL_BITS (8),
    .POLYNOMIAL      (8'h07),
    .CRC_INIT        (8'h00),
    .OUTPUT_FF       (1),
    .SCRUB_INTERVAL  (4),
    .ERR_CNT_WIDTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .inj_mask      (inj_mask),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .scrub_en      (scrub_en),
    .scrub_busy    (scrub_busy),
    .scrub_done    (scrub_done),
    .err_count     (err_count),
    .err_count_clr (err_count_clr),
    .err_addr      (err_addr),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    wr_en = 1'b1; addr = a; wr_data = d; inj_mask = m;
    tick();
    wr_en = 1'b0; inj_mask = 8'h00;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    inj_mask = '0; scrub_en = 1'b0; err_count_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_scrub_busy", 32'(scrub_busy), 0);

    // Clean write then read-after-write: two-cycle latency
    write(4'd3, 8'hA5, 8'h00);
    rd_en = 1'b1; addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("rd3_lat1_valid", 32'(rd_valid), 0);
    tick();
    chk("rd3_valid", 32'(rd_valid), 1);
    chk("rd3_data", 32'(rd_data), 32'hA5);
    chk("rd3_err", 32'(rd_err), 0);
    chk("rd3_err_count", 32'(err_count), 0);
    tick();
    chk("rd3_valid_pulse", 32'(rd_valid), 0);

    // Injected single-bit error
    write(4'd5, 8'h5A, 8'h01);
    rd_en = 1'b1; addr = 4'd5;
    tick();
    rd_en = 1'b0;
    tick();
    chk("rd5_data", 32'(rd_data), 32'h5B);
    chk("rd5_err", 32'(rd_err), 1);
    chk("rd5_err_count", 32'(err_count), 1);
    chk("rd5_err_addr", 32'(err_addr), 5);
    chk("rd5_sticky", 32'(err_sticky), 1);
    err_count_clr = 1'b1;
    tick();
    err_count_clr = 1'b0;
    chk("clr_err_count", 32'(err_count), 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_err_addr_kept", 32'(err_addr), 5);

    // Write and read together: write lands, no read issued
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'd7; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_rd_no_valid1", 32'(rd_valid), 0);
    tick();
    chk("wr_rd_no_valid2", 32'(rd_valid), 0);
    rd_en = 1'b1; addr = 4'd7;
    tick();
    rd_en = 1'b0;
    tick();
    chk("rd7_valid", 32'(rd_valid), 1);
    chk("rd7_data", 32'(rd_data), 32'h3C);

    // Scrub pass: word 5 repaired, word 9 corrupted in bit 7
    write(4'd5, 8'h5A, 8'h00);
    write(4'd9, 8'h11, 8'h80);
    scrub_en = 1'b1;
    tick();                                   // IDLE -> WAIT
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("wait_busy%0d", k), 32'(scrub_busy), 0);
    end
    tick();                                   // WAIT -> SCAN
    chk("scan_busy", 32'(scrub_busy), 1);
    repeat (9) tick();                        // words 0..8
    chk("scan_pre9_count", 32'(err_count), 0);
    tick();                                   // word 9
    chk("scan9_count", 32'(err_count), 1);
    chk("scan9_addr", 32'(err_addr), 9);
    repeat (5) tick();                        // words 10..14
    chk("scan_pre_done", 32'(scrub_done), 0);
    tick();                                   // word 15
    chk("scan_done", 32'(scrub_done), 1);
    chk("scan_done_busy", 32'(scrub_busy), 0);
    tick();
    chk("scan_done_pulse", 32'(scrub_done), 0);

    // Second pass with user reads stalling the scan at pointer 3
    err_count_clr = 1'b1;
    tick();
    err_count_clr = 1'b0;
    tick();
    tick();                                   // WAIT -> SCAN
    chk("pass2_busy", 32'(scrub_busy), 1);
    repeat (3) tick();                        // words 0..2
    rd_en = 1'b1; addr = 4'd3;
    repeat (10) tick();
    rd_en = 1'b0;
    chk("stall_rd_valid", 32'(rd_valid), 1);
    chk("stall_rd_data", 32'(rd_data), 32'hA5);
    chk("stall_err_count", 32'(err_count), 0);
    chk("stall_busy", 32'(scrub_busy), 1);
    repeat (6) tick();                        // words 3..8
    chk("resume_pre9_count", 32'(err_count), 0);
    tick();                                   // word 9
    chk("resume9_count", 32'(err_count), 1);
    chk("resume9_addr", 32'(err_addr), 9);
    scrub_en = 1'b0;
    tick();
    chk("scrub_off_busy", 32'(scrub_busy), 0);

    // Saturation of the 2-bit counter
    err_count_clr = 1'b1;
    tick();
    err_count_clr = 1'b0;
    rd_en = 1'b1; addr = 4'd9;
    repeat (5) tick();
    rd_en = 1'b0;
    tick();
    chk("sat_count", 32'(err_count), 3);
    chk("sat_sticky", 32'(err_sticky), 1);
    chk("sat_rd_data", 32'(rd_data), 32'h91);
    chk("sat_rd_err", 32'(rd_err), 1);
    rd_en = 1'b1; addr = 4'd9; err_count_clr = 1'b1;
    tick();
    rd_en = 1'b0; err_count_clr = 1'b0;
    chk("clr_evt_count", 32'(err_count), 1);
    chk("clr_evt_sticky", 32'(err_sticky), 1);

    // Reset mid-scan with a read in flight
    scrub_en = 1'b1;
    tick();
    repeat (4) tick();
    chk("rst_scan_busy", 32'(scrub_busy), 1);
    repeat (3) tick();
    rd_en = 1'b1; addr = 4'd3;
    tick();
    rd_en = 1'b0; rst = 1'b1; scrub_en = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_rd_data", 32'(rd_data), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    chk("midrst_err_addr", 32'(err_addr), 0);
    chk("midrst_sticky", 32'(err_sticky), 0);
    chk("midrst_busy", 32'(scrub_busy), 0);
    tick();
    chk("midrst_rd_valid2", 32'(rd_valid), 0);
    rd_en = 1'b1; addr = 4'd9;
    tick();
    rd_en = 1'b0;
    tick();
    chk("post_rst_rd_valid", 32'(rd_valid), 1);
    chk("post_rst_rd_data", 32'(rd_data), 0);
    chk("post_rst_rd_err", 32'(rd_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crc_mem_bank.md
Name: crc_mem_bank

Overview:
Parametrised successor to the single-word CRC-protected memory: a DEPTH-word addressable bank with per-word CRC check bits. It adds read/write addressing, an error-injection path for fault-injection campaigns, and a background scrubber FSM that re-checks idle words. It also keeps a saturating error counter with the last failing address. Instantiated per safety-relevant memory in the top-level DUT.

Parameters:
DATA_WIDTH, 32, data bits per word
DEPTH, 16, number of words; must be a power of 2, ADDR_WIDTH = $clog2(DEPTH)
POLYNOMIAL_BITS, 8, CRC width
POLYNOMIAL, 8'h07, generator polynomial, implicit x^POLYNOMIAL_BITS term
CRC_INIT, 0, LFSR seed
OUTPUT_FF, 1, 1 = extra output register stage on read path
SCRUB_INTERVAL, 256, idle cycles between scrub passes (>=1)
ERR_CNT_WIDTH, 8, error counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe
rd_en  in  1  read strobe
addr  in  ADDR_WIDTH  word address for rd/wr
wr_data  in  DATA_WIDTH  write data
inj_mask  in  DATA_WIDTH  XOR mask applied to stored data on write (0 = no injection)
rd_valid  out  1  read data valid pulse
rd_data  out  DATA_WIDTH  read data (raw stored word, uncorrected)
rd_err  out  1  CRC mismatch on this read, aligned with rd_valid
scrub_en  in  1  enable background scrubber
scrub_busy  out  1  scrubber in SCAN state
scrub_done  out  1  1-cycle pulse after last word of a pass is checked
err_count  out  ERR_CNT_WIDTH  saturating count of all detected errors (read + scrub)
err_count_clr  in  1  clear err_count
err_addr  out  ADDR_WIDTH  address of most recent detected error
err_sticky  out  1  set on any error, cleared only by err_count_clr or rst

Behaviour:
- Reset (rst=1 at a clk edge): every word is set to data 0 with its CRC = crc(0). All outputs become 0. Scrubber goes to IDLE with pointer 0 and interval counter 0. A read after reset returns 0 with rd_err=0.
- CRC: serial LFSR over DATA_WIDTH bits, MSB first, no reflection, no final XOR, seed CRC_INIT. Computed combinationally in one cycle.
- Write: wr_en=1 stores {wr_data ^ inj_mask, crc(wr_data)} at addr at the clock edge. Injection therefore yields a guaranteed-detectable mismatch for any nonzero mask whose syndrome is nonzero.
- wr_en and rd_en both high: the write is performed and the read is ignored (no rd_valid).
- Read path: stage 1 registers the word and the check result. rd_valid/rd_data/rd_err appear 1 cycle after rd_en when OUTPUT_FF=0, 2 cycles after when OUTPUT_FF=1. Back-to-back reads are fully pipelined, one per cycle.
- Read-after-write to the same address in the next cycle returns the new data.
- A single checker is shared between user reads and the scrubber. The user port always has priority; the scrubber uses only cycles with wr_en=0 and rd_en=0.
- Scrubber FSM:
  - IDLE -> WAIT when scrub_en=1.
  - WAIT: counter counts up to SCRUB_INTERVAL-1 -> SCAN, pointer=0.
  - SCAN: on each free cycle, check word[pointer] and increment the pointer. A stalled cycle holds the pointer. After checking word DEPTH-1, pulse scrub_done and go to WAIT with the counter cleared.
  - scrub_en=0 in any state -> IDLE next cycle, pointer and counter cleared.
- The scrubber never writes memory; detection only.
- Error event (user read check or scrub check mismatch, at check time):
  - err_count += 1, saturating at all-ones.
  - err_addr <= checked address.
  - err_sticky <= 1.
- err_count_clr with a simultaneous error event: err_count=1, err_sticky=1. err_count_clr alone: err_count=0, err_sticky=0, err_addr unchanged.
- Reset mid-scan or mid-read discards in-flight reads (no rd_valid) and the scan position.

Decomposition:
- Package crc_mem_pkg:
  - scrub_state_t enum {S_IDLE, S_WAIT, S_SCAN}
  - function crc_compute(data, poly, init), parametrised via width arguments
  - saturating-increment helper
- One sub-module, crc_mem_scrub_fsm: owns state, interval counter, pointer, scrub_busy and scrub_done. It takes a port_free input and produces a scrub_check strobe and address.

Test Plan:
- DATA_WIDTH=8, POLY=0x07, OUTPUT_FF=1: write 0xA5 @3, read @3 -> rd_valid 2 cycles later, rd_data=0xA5, rd_err=0, err_count=0.
- Write 0x5A @5 with inj_mask=0x01, read @5 -> rd_data=0x5B, rd_err=1, err_count=1, err_addr=5, err_sticky=1. err_count_clr -> err_count=0, err_sticky=0.
- DEPTH=16, SCRUB_INTERVAL=4: corrupt @9 (mask 0x80), scrub_en=1, no user traffic -> scrub_busy after 4 cycles, error at scan of word 9: err_count=1, err_addr=9. scrub_done 16 cycles after SCAN entry.
- Continuous reads during SCAN -> pointer frozen, no scrub checks. Traffic stops -> pointer resumes from the held value. wr_en&rd_en same cycle -> write lands, no rd_valid.
- ERR_CNT_WIDTH=2: 5 injected-error reads -> err_count=3 (saturated). err_count_clr coincident with an error read -> err_count=1.
- rst asserted mid-SCAN with a read in flight -> no rd_valid, all outputs 0, read @9 -> 0x00, rd_err=0.
